scu_dsp_dma_bridge: RTL and testbench
=====================================

SCU_DSP_DMA_BRIDGE -- requirements
Module: scu_dsp_dma_bridge

Interface
REQ-001 SHALL have port CLK, input, 1: system clock; all state changes on rising edge.
REQ-002 SHALL have port RST_N, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port CE_R, input, 1: clock enable; every state or register update is qualified by CE_R.
REQ-004 SHALL have port DSP_A, input, [26:2]: DSP DMA word address.
REQ-005 SHALL have port DSP_DO, input, 32: DSP write data.
REQ-006 SHALL have port DSP_WE, input, 1: 1 = DSP-to-bus write, 0 = bus-to-DSP read.
REQ-007 SHALL have port DSP_REQ, input, 1: one-word request pulse from the DSP.
REQ-008 SHALL have port DSP_ACK, output, 1: one-word completion strobe to the DSP.
REQ-009 SHALL have port DSP_DI, output, 32: read data returned to the DSP.
REQ-010 SHALL have port ARB_REQ, output, 1: bus ownership request to the SCU arbiter.
REQ-011 SHALL have port ARB_GNT, input, 1: bus ownership grant from the SCU arbiter.
REQ-012 SHALL have port BUS_A, output, [26:0]: byte address, equal to {DSP_A, 2'b00}.
REQ-013 SHALL have port BUS_SEL, output, 2: target region (0 = A-bus, 1 = B-bus, 2 = WRAM).
REQ-014 SHALL have port BUS_REQ, output, 1: bus cycle strobe.
REQ-015 SHALL have port BUS_WE, output, 1: bus write enable.
REQ-016 SHALL have port BUS_DO, output, 32: bus write data.
REQ-017 SHALL have port BUS_DI, input, 32: bus read data.
REQ-018 SHALL have port BUS_RDY, input, 1: bus cycle completion.
REQ-019 SHALL have port ERR, output, 1: sticky error flag.
REQ-020 SHALL have port ERR_CLR, input, 1: error flag clear.
REQ-021 SHALL have port BUSY, output, 1: asserted whenever the FSM is not IDLE.

Function
REQ-022 FSM states SHALL be IDLE, ARB, XFER, ACK; every transition and register update SHALL occur only on cycles where CE_R = 1.
REQ-023 IDLE SHALL, on DSP_REQ = 1, latch DSP_A, DSP_DO and DSP_WE and decode the byte address as follows: 0x2000000-0x58FFFFF -> A-bus; 0x5A00000-0x5FFFFFF -> B-bus; 0x6000000-0x7FFFFFF -> WRAM; any other address -> illegal.
REQ-024 For a legal address, IDLE SHALL go to ARB; for an illegal address, IDLE SHALL set ERR, load DSP_DI = 0 and go to ACK without any bus activity.
REQ-025 ARB SHALL hold ARB_REQ = 1 and SHALL go to XFER on the first CE_R cycle that sees ARB_GNT = 1.
REQ-026 XFER SHALL hold BUS_REQ = 1 with stable BUS_A, BUS_SEL, BUS_WE and BUS_DO, and SHALL keep ARB_REQ = 1.
REQ-027 XFER SHALL go to ACK on BUS_RDY = 1; on a read, it SHALL capture BUS_DI into DSP_DI on that same cycle.
REQ-028 An 8-bit timeout counter SHALL clear on XFER entry and increment each CE_R cycle in XFER; if it reaches 255 without BUS_RDY, XFER SHALL set ERR, force DSP_DI = 0, drop BUS_REQ and go to ACK.
REQ-029 ACK SHALL drive DSP_ACK = 1 for exactly one CE_R cycle with DSP_DI valid, deassert ARB_REQ and BUS_REQ, then return to IDLE.
REQ-030 Minimum latency from DSP_REQ to DSP_ACK SHALL be 3 CE_R cycles (ARB_GNT and BUS_RDY both immediate).
REQ-031 DSP_REQ seen in any state other than IDLE SHALL be ignored and SHALL set ERR.
REQ-032 DSP_DI SHALL hold its value until the next capture; writes SHALL leave DSP_DI unchanged.
REQ-033 If ERR_CLR and an error event occur in the same cycle, the error event SHALL win and ERR SHALL be set.
REQ-034 An ARB_GNT drop during XFER SHALL be ignored; the current cycle SHALL complete.

Reset
REQ-035 While RST_N = 0, the FSM SHALL be IDLE, and DSP_ACK, ARB_REQ, BUS_REQ, BUS_WE, ERR, BUSY, the timeout counter, BUS_A, BUS_SEL, BUS_DO and DSP_DI SHALL all be 0.
REQ-036 Reset asserted mid-transfer SHALL drop all strobes immediately, and no DSP_ACK SHALL be issued afterward.

Structure
REQ-037 The state enum, the region enum, the region base/limit constants and the timeout constant (255) SHALL live in SCUDSP_PKG, alongside a pure region-decode function.
REQ-038 The block SHALL be a single module with no sub-modules.

Verification
REQ-039 WRAM read: DSP_A = 0x6000040>>2, ARB_GNT and BUS_RDY immediate, BUS_DI = 0xDEADBEEF -> BUS_A = 0x6000040, BUS_SEL = 2, DSP_ACK 3 cycles after DSP_REQ, DSP_DI = 0xDEADBEEF.
REQ-040 B-bus write with 5 wait states: DSP_A = 0x5A00010>>2, DSP_DO = 0x12345678 -> BUS_WE = 1, BUS_DO = 0x12345678 held for 6 cycles, a single DSP_ACK, ERR = 0.
REQ-041 Illegal address 0x0100000 -> ARB_REQ never asserted, DSP_ACK after 1 cycle, DSP_DI = 0, ERR = 1; ERR_CLR -> ERR = 0.
REQ-042 Timeout: BUS_RDY held at 0 -> DSP_ACK after 255 XFER cycles, ERR = 1, BUS_REQ = 0.
REQ-043 Second DSP_REQ during XFER, plus reset asserted mid-XFER -> ERR = 1 from the extra request; after reset all outputs = 0, FSM IDLE, no stray DSP_ACK.

Source files
------------

// File: rtl/scu_dsp_dma_bridge_pkg.sv
// Shared types, address map and timeout limit for the SCU DSP DMA bridge.
// The package also holds the pure decode from a byte address to a bus region.
package SCUDSP_PKG;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB  = 2'd1,
      ST_XFER = 2'd2,
      ST_ACK  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      REGION_ABUS    = 2'd0,
      REGION_BBUS    = 2'd1,
      REGION_WRAM    = 2'd2,
      REGION_ILLEGAL = 2'd3
   } region_t;

   localparam logic [26:0] ABUS_BASE  = 27'h2000000;
   localparam logic [26:0] ABUS_LIMIT = 27'h58FFFFF;
   localparam logic [26:0] BBUS_BASE  = 27'h5A00000;
   localparam logic [26:0] BBUS_LIMIT = 27'h5FFFFFF;
   localparam logic [26:0] WRAM_BASE  = 27'h6000000;
   localparam logic [26:0] WRAM_LIMIT = 27'h7FFFFFF;

   localparam logic [7:0] XFER_TIMEOUT = 8'd255;

   // Offset form keeps the WRAM limit check meaningful at the top of the 27-bit space.
   function automatic logic in_window(input logic [26:0] addr,
                                      input logic [26:0] base,
                                      input logic [26:0] limit);
      return (addr >= base) && ((addr - base) <= (limit - base));
   endfunction

   function automatic region_t decode_region(input logic [26:0] addr);
      region_t region;
      region = REGION_ILLEGAL;
      if (in_window(addr, ABUS_BASE, ABUS_LIMIT))
         region = REGION_ABUS;
      else if (in_window(addr, BBUS_BASE, BBUS_LIMIT))
         region = REGION_BBUS;
      else if (in_window(addr, WRAM_BASE, WRAM_LIMIT))
         region = REGION_WRAM;
      return region;
   endfunction

endpackage

// File: rtl/scu_dsp_dma_bridge_if.sv
// SCU-side arbitration and bus-cycle signals of the DSP DMA bridge.
// The bridge is the master; the arbiter and bus targets sit on the slave side.
interface scu_dsp_dma_bridge_if;

   logic        ARB_REQ;
   logic        ARB_GNT;
   logic [26:0] BUS_A;
   logic [1:0]  BUS_SEL;
   logic        BUS_REQ;
   logic        BUS_WE;
   logic [31:0] BUS_DO;
   logic [31:0] BUS_DI;
   logic        BUS_RDY;

   modport master (
      output ARB_REQ, BUS_A, BUS_SEL, BUS_REQ, BUS_WE, BUS_DO,
      input  ARB_GNT, BUS_DI, BUS_RDY
   );

   modport slave (
      input  ARB_REQ, BUS_A, BUS_SEL, BUS_REQ, BUS_WE, BUS_DO,
      output ARB_GNT, BUS_DI, BUS_RDY
   );

endinterface

// File: rtl/scu_dsp_dma_bridge.sv
// Single-word DMA bridge from the SCU DSP onto the A-bus, B-bus or work RAM.
// Each request is arbitrated, run as one bus cycle (with timeout) and acknowledged.
module scu_dsp_dma_bridge
   import SCUDSP_PKG::*;
(
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        CE_R,
   input  logic [26:2] DSP_A,
   input  logic [31:0] DSP_DO,
   input  logic        DSP_WE,
   input  logic        DSP_REQ,
   output logic        DSP_ACK,
   output logic [31:0] DSP_DI,
   input  logic        ERR_CLR,
   output logic        ERR,
   output logic        BUSY,
   scu_dsp_dma_bridge_if.master bus
);

   state_t      state_q;
   state_t      state_d;
   logic [26:0] bus_a_q;
   region_t     sel_q;
   logic        we_q;
   logic [31:0] do_q;
   logic [31:0] di_q;
   logic        err_q;
   logic [7:0]  tmo_q;

   logic        latch_req;
   logic        load_di;
   logic [31:0] di_next;
   logic        err_event;
   logic        tmo_clr;
   logic        tmo_inc;
   region_t     req_region;

   assign req_region = decode_region({DSP_A, 2'b00});

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         state_q <= ST_IDLE;
      else if (CE_R)
         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      latch_req = 1'b0;
      load_di   = 1'b0;
      di_next   = bus.BUS_DI;
      err_event = 1'b0;
      tmo_clr   = 1'b0;
      tmo_inc   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (DSP_REQ) begin
               latch_req = 1'b1;
               if (req_region == REGION_ILLEGAL) begin
                  err_event = 1'b1;
                  load_di   = 1'b1;
                  di_next   = '0;
                  state_d   = ST_ACK;
               end else begin
                  state_d = ST_ARB;
               end
            end
         end
         ST_ARB: begin
            if (bus.ARB_GNT) begin
               tmo_clr = 1'b1;
               state_d = ST_XFER;
            end
         end
         // The grant is not re-checked here: once started, a bus cycle always completes.
         ST_XFER: begin
            tmo_inc = 1'b1;
            if (bus.BUS_RDY) begin
               load_di = !we_q;
               state_d = ST_ACK;
            end else if (tmo_q == XFER_TIMEOUT - 8'd1) begin
               err_event = 1'b1;
               load_di   = 1'b1;
               di_next   = '0;
               state_d   = ST_ACK;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (DSP_REQ && (state_q != ST_IDLE))
         err_event = 1'b1;
   end

   // A new error event takes priority over a simultaneous ERR_CLR.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         bus_a_q <= '0;
         sel_q   <= REGION_ABUS;
         we_q    <= 1'b0;
         do_q    <= '0;
         di_q    <= '0;
         err_q   <= 1'b0;
         tmo_q   <= '0;
      end else if (CE_R) begin
         if (latch_req) begin
            bus_a_q <= {DSP_A, 2'b00};
            sel_q   <= req_region;
            we_q    <= DSP_WE;
            do_q    <= DSP_DO;
         end
         if (load_di)
            di_q <= di_next;
         if (tmo_clr)
            tmo_q <= '0;
         else if (tmo_inc)
            tmo_q <= tmo_q + 8'd1;
         if (err_event)
            err_q <= 1'b1;
         else if (ERR_CLR)
            err_q <= 1'b0;
      end
   end

   assign DSP_ACK     = (state_q == ST_ACK);
   assign DSP_DI      = di_q;
   assign ERR         = err_q;
   assign BUSY        = (state_q != ST_IDLE);
   assign bus.ARB_REQ = (state_q == ST_ARB) || (state_q == ST_XFER);
   assign bus.BUS_REQ = (state_q == ST_XFER);
   // Write enable only shows during a live bus cycle so an idle bus never looks like a write.
   assign bus.BUS_WE  = we_q && (state_q == ST_XFER);
   assign bus.BUS_A   = bus_a_q;
   assign bus.BUS_SEL = sel_q;
   assign bus.BUS_DO  = do_q;

endmodule

// File: tb/tb_scu_dsp_dma_bridge.sv
// Scoreboard bench for scu_dsp_dma_bridge: directed requests push expected
// acknowledge and bus-cycle records that two monitors pop and compare.
module tb_scu_dsp_dma_bridge;

   typedef struct {
      logic [31:0] di;
      logic        err;
      int          req_cyc;
      int          lat;
   } ack_exp_t;

   typedef struct {
      logic [26:0] a;
      logic [1:0]  sel;
      logic        we;
      logic [31:0] wd;
      int          hold;
   } bus_exp_t;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        CE_R;
   logic [26:2] DSP_A;
   logic [31:0] DSP_DO;
   logic        DSP_WE;
   logic        DSP_REQ;
   logic        DSP_ACK;
   logic [31:0] DSP_DI;
   logic        ERR_CLR;
   logic        ERR;
   logic        BUSY;

   scu_dsp_dma_bridge_if bus ();

   scu_dsp_dma_bridge dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .CE_R    (CE_R),
      .DSP_A   (DSP_A),
      .DSP_DO  (DSP_DO),
      .DSP_WE  (DSP_WE),
      .DSP_REQ (DSP_REQ),
      .DSP_ACK (DSP_ACK),
      .DSP_DI  (DSP_DI),
      .ERR_CLR (ERR_CLR),
      .ERR     (ERR),
      .BUSY    (BUSY),
      .bus     (bus)
   );

   ack_exp_t ack_q[$];
   bus_exp_t bus_q[$];
   int       checks     = 0;
   int       errors     = 0;
   int       cyc        = 0;
   int       arb_cycles = 0;
   int       rdy_wait   = 0;
   bit       rdy_never  = 1'b0;
   int       wait_cnt   = 0;

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc++;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // Bus target model: BUS_RDY after rdy_wait wait states, or never.
   always @(negedge CLK) begin
      if (bus.BUS_REQ) begin
         bus.BUS_RDY = !rdy_never && (wait_cnt >= rdy_wait);
         wait_cnt++;
      end else begin
         bus.BUS_RDY = 1'b0;
         wait_cnt    = 0;
      end
   end

   always @(negedge CLK) if (bus.ARB_REQ) arb_cycles++;

   ack_exp_t ack_cur;
   always @(negedge CLK) begin
      if (DSP_ACK) begin
         if (ack_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_ack: got DSP_ACK=1 at cycle %0d expected none", cyc);
         end else begin
            ack_cur = ack_q.pop_front();
            checkOutput("dsp_di", DSP_DI, ack_cur.di);
            checkOutput("err_at_ack", {31'd0, ERR}, {31'd0, ack_cur.err});
            checkOutput("ack_latency", cyc - ack_cur.req_cyc, ack_cur.lat);
         end
      end
   end

   bus_exp_t bus_cur;
   bit       in_xfer   = 1'b0;
   bit       have_cur  = 1'b0;
   bit       stable_ok = 1'b1;
   int       hold_cnt  = 0;
   always @(negedge CLK) begin
      if (bus.BUS_REQ) begin
         if (!in_xfer) begin
            in_xfer   = 1'b1;
            hold_cnt  = 0;
            stable_ok = 1'b1;
            if (bus_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_bus_req: got BUS_REQ=1 at cycle %0d expected none", cyc);
            end else begin
               bus_cur  = bus_q.pop_front();
               have_cur = 1'b1;
               checkOutput("bus_a", {5'd0, bus.BUS_A}, {5'd0, bus_cur.a});
               checkOutput("bus_sel", {30'd0, bus.BUS_SEL}, {30'd0, bus_cur.sel});
               checkOutput("bus_we", {31'd0, bus.BUS_WE}, {31'd0, bus_cur.we});
               checkOutput("bus_do", bus.BUS_DO, bus_cur.wd);
            end
         end else if (have_cur) begin
            if (bus.BUS_A !== bus_cur.a || bus.BUS_SEL !== bus_cur.sel ||
                bus.BUS_WE !== bus_cur.we || bus.BUS_DO !== bus_cur.wd)
               stable_ok = 1'b0;
         end
         hold_cnt++;
      end else if (in_xfer) begin
         in_xfer = 1'b0;
         if (have_cur) begin
            checkOutput("bus_hold_cycles", hold_cnt, bus_cur.hold);
            checkOutput("bus_stable", {31'd0, stable_ok}, 32'd1);
            have_cur = 1'b0;
         end
      end
   end

   task automatic applyStimulus(input logic [26:0] addr, input logic we,
                                input logic [31:0] wdata, input bit exp_ack,
                                input logic [31:0] exp_di, input logic exp_err,
                                input int exp_lat, input bit exp_bus,
                                input logic [1:0] exp_sel, input int exp_hold);
      ack_exp_t ae;
      bus_exp_t be;
      DSP_A   = addr[26:2];
      DSP_DO  = wdata;
      DSP_WE  = we;
      DSP_REQ = 1'b1;
      if (exp_ack) begin
         ae.di      = exp_di;
         ae.err     = exp_err;
         ae.req_cyc = cyc;
         ae.lat     = exp_lat;
         ack_q.push_back(ae);
      end
      if (exp_bus) begin
         be.a    = addr;
         be.sel  = exp_sel;
         be.we   = we;
         be.wd   = wdata;
         be.hold = exp_hold;
         bus_q.push_back(be);
      end
      @(negedge CLK);
      DSP_REQ = 1'b0;
   endtask

   task automatic waitIdle(input int budget);
      int n;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (BUSY && n < budget);
      if (BUSY) begin
         checks++;
         errors++;
         $display("[TB] FAIL wait_idle: got BUSY=1 after %0d cycles expected 0", budget);
      end
   endtask

   task automatic pulseErrClr();
      ERR_CLR = 1'b1;
      @(negedge CLK);
      ERR_CLR = 1'b0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_dsp_ack"}, {31'd0, DSP_ACK}, 32'd0);
      checkOutput({tag, "_arb_req"}, {31'd0, bus.ARB_REQ}, 32'd0);
      checkOutput({tag, "_bus_req"}, {31'd0, bus.BUS_REQ}, 32'd0);
      checkOutput({tag, "_bus_we"}, {31'd0, bus.BUS_WE}, 32'd0);
      checkOutput({tag, "_err"}, {31'd0, ERR}, 32'd0);
      checkOutput({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
      checkOutput({tag, "_bus_a"}, {5'd0, bus.BUS_A}, 32'd0);
      checkOutput({tag, "_bus_sel"}, {30'd0, bus.BUS_SEL}, 32'd0);
      checkOutput({tag, "_bus_do"}, bus.BUS_DO, 32'd0);
      checkOutput({tag, "_dsp_di"}, DSP_DI, 32'd0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no finish by cycle %0d expected finish", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int arb_before;
      RST_N       = 1'b0;
      CE_R        = 1'b1;
      DSP_A       = '0;
      DSP_DO      = '0;
      DSP_WE      = 1'b0;
      DSP_REQ     = 1'b0;
      ERR_CLR     = 1'b0;
      bus.ARB_GNT = 1'b0;
      bus.BUS_DI  = '0;
      repeat (3) @(negedge CLK);
      checkAllZero("reset");
      RST_N       = 1'b1;
      bus.ARB_GNT = 1'b1;
      @(negedge CLK);

      $display("[TB] WRAM read, immediate grant and ready");
      bus.BUS_DI = 32'hDEADBEEF;
      rdy_wait   = 0;
      applyStimulus(27'h6000040, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 3, 1'b1, 2'd2, 1);
      waitIdle(20);

      $display("[TB] B-bus write with 5 wait states");
      rdy_wait = 5;
      applyStimulus(27'h5A00010, 1'b1, 32'h12345678, 1'b1, 32'hDEADBEEF, 1'b0, 8, 1'b1, 2'd1, 6);
      waitIdle(30);

      $display("[TB] illegal address below A-bus");
      rdy_wait   = 0;
      arb_before = arb_cycles;
      applyStimulus(27'h0100000, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1, 1'b0, 2'd0, 0);
      waitIdle(10);
      checkOutput("illegal_no_arb", arb_cycles, arb_before);
      pulseErrClr();
      checkOutput("err_cleared", {31'd0, ERR}, 32'd0);

      $display("[TB] illegal gap address with simultaneous ERR_CLR");
      ERR_CLR = 1'b1;
      applyStimulus(27'h5900000, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1, 1'b0, 2'd0, 0);
      ERR_CLR = 1'b0;
      waitIdle(10);
      checkOutput("err_wins_over_clr", {31'd0, ERR}, 32'd1);
      pulseErrClr();
      checkOutput("err_cleared_again", {31'd0, ERR}, 32'd0);

      $display("[TB] A-bus top word read with delayed grant");
      bus.ARB_GNT = 1'b0;
      bus.BUS_DI  = 32'hA5A50001;
      applyStimulus(27'h58FFFFC, 1'b0, 32'h0, 1'b1, 32'hA5A50001, 1'b0, 6, 1'b1, 2'd0, 1);
      checkOutput("arb_req_waiting", {31'd0, bus.ARB_REQ}, 32'd1);
      checkOutput("bus_req_waiting", {31'd0, bus.BUS_REQ}, 32'd0);
      checkOutput("busy_waiting", {31'd0, BUSY}, 32'd1);
      repeat (3) @(negedge CLK);
      bus.ARB_GNT = 1'b1;
      waitIdle(20);

      $display("[TB] A-bus base write leaves DSP_DI unchanged");
      applyStimulus(27'h2000000, 1'b1, 32'hCAFEF00D, 1'b1, 32'hA5A50001, 1'b0, 3, 1'b1, 2'd0, 1);
      waitIdle(20);

      $display("[TB] WRAM top word read timeout");
      rdy_never = 1'b1;
      applyStimulus(27'h7FFFFFC, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 257, 1'b1, 2'd2, 255);
      waitIdle(300);
      checkOutput("bus_req_after_timeout", {31'd0, bus.BUS_REQ}, 32'd0);
      pulseErrClr();
      checkOutput("err_cleared_timeout", {31'd0, ERR}, 32'd0);

      $display("[TB] extra request during XFER, then reset mid-transfer");
      applyStimulus(27'h6000100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0, 1'b1, 2'd2, 2);
      @(negedge CLK);
      DSP_REQ = 1'b1;
      @(negedge CLK);
      DSP_REQ = 1'b0;
      checkOutput("err_extra_req", {31'd0, ERR}, 32'd1);
      checkOutput("busy_before_reset", {31'd0, BUSY}, 32'd1);
      #2 RST_N = 1'b0;
      #1 checkAllZero("mid_xfer_reset");
      rdy_never = 1'b0;
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      repeat (10) @(negedge CLK);
      checkAllZero("after_reset");

      checkOutput("ack_queue_empty", ack_q.size(), 32'd0);
      checkOutput("bus_queue_empty", bus_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
